seg7_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the shared 7-seg character decoder. Steps the decoder's

---
 rtl/seg7_scan_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-seg scan controller: steps char_num over the digits, blanks each slot start,
// and hands the decoder a frame-stable STATE copy. Optional blink of WRONG/LOSE via SEG7_BLINK_EN.
module seg7_scan_ctrl #(
   parameter int NUM_DIG      = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYC    = 500,
   parameter int BLINK_FRAMES = 32
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic               SCAN_EN,
   input  logic [3:0]         STATE_IN,
   output logic [3:0]         STATE_OUT,
   output logic [2:0]         char_num,
   output logic [NUM_DIG-1:0] nDIG,
   output logic               frame_tick
);

   localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BLANK = 2'd1;
   localparam logic [1:0] S_DRIVE = 2'd2;

   // Slot entry state: with no blanking gap a slot starts directly in DRIVE.
   localparam logic [1:0]    S_START    = (BLANK_CYC == 0) ? S_DRIVE : S_BLANK;
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] BLANK_LAST = PW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
   localparam logic [2:0]    SLOT_LAST  = 3'(NUM_DIG - 1);

   if (NUM_DIG < 1 || NUM_DIG > 8) begin : g_bad_num_dig
      $error("seg7_scan_ctrl: NUM_DIG must be 1..8");
   end
   if (SCAN_DIV < 2) begin : g_bad_scan_div
      $error("seg7_scan_ctrl: SCAN_DIV must be >= 2");
   end
   if (BLANK_CYC < 0 || BLANK_CYC >= SCAN_DIV) begin : g_bad_blank_cyc
      $error("seg7_scan_ctrl: BLANK_CYC must be 0..SCAN_DIV-1");
   end

   logic [1:0]         fsm_q, fsm_d;
   logic [PW-1:0]      presc_q, presc_d;
   logic [2:0]         slot_q, slot_d;
   logic [3:0]         state_out_q, state_out_d;
   logic               frame_tick_q, frame_tick_d;
   logic [NUM_DIG-1:0] ndig_q, ndig_d;
   logic               blink_off;

   always_comb begin
      fsm_d        = fsm_q;
      presc_d      = presc_q;
      slot_d       = slot_q;
      state_out_d  = state_out_q;
      frame_tick_d = 1'b0;
      case (fsm_q)
         S_IDLE: begin
            if (SCAN_EN) begin
               fsm_d        = S_START;
               presc_d      = '0;
               slot_d       = '0;
               state_out_d  = STATE_IN;
               frame_tick_d = 1'b1;
            end
         end
         S_BLANK: begin
            if (!SCAN_EN) begin
               fsm_d   = S_IDLE;
               presc_d = '0;
               slot_d  = '0;
            end else begin
               presc_d = presc_q + 1'b1;
               if (presc_q == BLANK_LAST) begin
                  fsm_d = S_DRIVE;
               end
            end
         end
         S_DRIVE: begin
            if (!SCAN_EN) begin
               fsm_d   = S_IDLE;
               presc_d = '0;
               slot_d  = '0;
            end else if (presc_q == PRESC_LAST) begin
               fsm_d   = S_START;
               presc_d = '0;
               if (slot_q == SLOT_LAST) begin
                  slot_d       = '0;
                  state_out_d  = STATE_IN;
                  frame_tick_d = 1'b1;
               end else begin
                  slot_d = slot_q + 1'b1;
               end
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         default: begin
            fsm_d   = S_IDLE;
            presc_d = '0;
            slot_d  = '0;
         end
      endcase
   end

`ifdef SEG7_BLINK_EN
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   if (BLINK_FRAMES < 1) begin : g_bad_blink_frames
      $error("seg7_scan_ctrl: BLINK_FRAMES must be >= 1");
   end

   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          phase_q, phase_d;
   logic          wrap;

   // A tick out of DRIVE is a slot wrap; the IDLE start tick is not counted as a frame.
   assign wrap = frame_tick_d && (fsm_q == S_DRIVE);

   always_comb begin
      fcnt_d  = fcnt_q;
      phase_d = phase_q;
      if (state_out_d != state_out_q) begin
         fcnt_d  = '0;
         phase_d = 1'b0;
      end else if (wrap) begin
         if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
            fcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
   end

   assign blink_off = phase_d && (state_out_d == 4'b0111 || state_out_d == 4'b1011);

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         fcnt_q  <= '0;
         phase_q <= 1'b0;
      end else begin
         fcnt_q  <= fcnt_d;
         phase_q <= phase_d;
      end
   end
`else
   assign blink_off = 1'b0;
`endif

   // Enables are derived from next-state values so nDIG lines up with the registered FSM.
   always_comb begin
      ndig_d = '1;
      if (fsm_d == S_DRIVE && !blink_off) begin
         ndig_d = ~(NUM_DIG'(1) << slot_d);
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         fsm_q        <= S_IDLE;
         presc_q      <= '0;
         slot_q       <= '0;
         state_out_q  <= 4'b0000;
         frame_tick_q <= 1'b0;
         ndig_q       <= '1;
      end else begin
         fsm_q        <= fsm_d;
         presc_q      <= presc_d;
         slot_q       <= slot_d;
         state_out_q  <= state_out_d;
         frame_tick_q <= frame_tick_d;
         ndig_q       <= ndig_d;
      end
   end

   assign STATE_OUT  = state_out_q;
   assign char_num   = slot_q;
   assign nDIG       = ndig_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a frame-time model queues expected outputs per cycle.
module tb_seg7_scan_ctrl;
   localparam int ND = 4;
   localparam int SD = 8;
   localparam int BC = 2;
   localparam int BF = 2;
   localparam int FRAME = SD * ND;

   logic          CLK = 1'b0;
   logic          nRST = 1'b0;
   logic          SCAN_EN = 1'b0;
   logic [3:0]    STATE_IN = 4'b0000;
   logic [3:0]    STATE_OUT, state_out0;
   logic [2:0]    char_num, char_num0;
   logic [ND-1:0] nDIG, ndig0;
   logic          frame_tick, frame_tick0;

   always #5 CLK = ~CLK;

   seg7_scan_ctrl #(.NUM_DIG(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
      .CLK(CLK), .nRST(nRST), .SCAN_EN(SCAN_EN), .STATE_IN(STATE_IN),
      .STATE_OUT(STATE_OUT), .char_num(char_num), .nDIG(nDIG), .frame_tick(frame_tick));

   seg7_scan_ctrl #(.NUM_DIG(ND), .SCAN_DIV(SD), .BLANK_CYC(0), .BLINK_FRAMES(BF)) dut0 (
      .CLK(CLK), .nRST(nRST), .SCAN_EN(SCAN_EN), .STATE_IN(STATE_IN),
      .STATE_OUT(state_out0), .char_num(char_num0), .nDIG(ndig0), .frame_tick(frame_tick0));

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Model state: m_t is cycles since the scan started, m_frames counts frames since STATE_OUT changed.
   bit         m_run = 1'b0;
   int         m_t = 0;
   logic [3:0] m_so = 4'b0000;
   int         m_frames = 0;

   logic [11:0] exp_q[$];
   logic [6:0]  exp0_q[$];

   function automatic logic [11:0] model_step(logic rst_n, logic en, logic [3:0] sin);
      logic       ft;
      logic       dark;
      logic [3:0] one;
      logic [3:0] nd;
      logic [2:0] ch;
      int         slot;
      int         pos;
      ft  = 1'b0;
      one = 4'b0001;
      if (!rst_n) begin
         m_run = 1'b0; m_t = 0; m_so = 4'b0000; m_frames = 0;
      end else if (!en) begin
         m_run = 1'b0; m_t = 0;
      end else if (!m_run) begin
         m_run = 1'b1; m_t = 0; ft = 1'b1;
         if (sin != m_so) m_frames = 0;
         m_so = sin;
      end else begin
         m_t++;
         if (m_t % FRAME == 0) begin
            ft = 1'b1;
            if (sin != m_so) m_frames = 0;
            else m_frames++;
            m_so = sin;
         end
      end
      slot = (m_t / SD) % ND;
      pos  = m_t % SD;
      dark = 1'b0;
`ifdef SEG7_BLINK_EN
      dark = (((m_frames / BF) % 2) == 1) && (m_so == 4'b0111 || m_so == 4'b1011);
`endif
      nd = 4'b1111;
      if (m_run && pos >= BC && !dark) nd = ~(one << slot);
      ch = m_run ? 3'(slot) : 3'd0;
      return {nd, ch, m_so, ft};
   endfunction

   function automatic logic [6:0] model0();
      logic [3:0] one;
      int         slot;
      one  = 4'b0001;
      slot = (m_t / SD) % ND;
      if (!m_run) return {4'b1111, 3'd0};
      return {~(one << slot), 3'(slot)};
   endfunction

   task automatic tick(output logic [11:0] exp, output logic [11:0] obs,
                       output logic [6:0] exp0, output logic [6:0] obs0);
      exp_q.push_back(model_step(nRST, SCAN_EN, STATE_IN));
      exp0_q.push_back(model0());
      @(posedge CLK);
      #1;
      exp  = exp_q.pop_front();
      exp0 = exp0_q.pop_front();
      obs  = {nDIG, char_num, STATE_OUT, frame_tick};
      obs0 = {ndig0, char_num0};
      cyc++;
      $display("cyc %0d rst_n=%b en=%b in=%b | nDIG=%b char=%0d so=%b ft=%b | nDIG0=%b",
               cyc, nRST, SCAN_EN, STATE_IN, nDIG, char_num, STATE_OUT, frame_tick, ndig0);
   endtask

   task automatic test_reset();
      logic [11:0] e, o;
      logic [6:0]  e0, o0;
      nRST = 1'b0; SCAN_EN = 1'b0; STATE_IN = 4'b0010;
      repeat (5) begin
         tick(e, o, e0, o0);
         checks++;
         if (o !== e || o !== 12'b1111_000_0000_0) begin
            errors++;
            $display("FAIL reset cyc=%0d got=%b exp=%b", cyc, o, e);
         end
      end
   endtask

   task automatic test_scan();
      logic [11:0] e, o;
      logic [6:0]  e0, o0;
      nRST = 1'b1; SCAN_EN = 1'b1; STATE_IN = 4'b0010;
      repeat (2 * FRAME + 4) begin
         tick(e, o, e0, o0);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL scan cyc=%0d got=%b exp=%b", cyc, o, e);
         end
      end
   endtask

   task automatic test_frame_latch();
      logic [11:0] e, o;
      logic [6:0]  e0, o0;
      int ticks_seen;
      for (int i = 0; i < 2 * FRAME && (m_t % FRAME) != 2 * SD + 3; i++) begin
         tick(e, o, e0, o0);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL latch_pre cyc=%0d got=%b exp=%b", cyc, o, e);
         end
      end
      STATE_IN = 4'b0100;
      ticks_seen = 0;
      repeat (2 * FRAME) begin
         tick(e, o, e0, o0);
         ticks_seen += int'(o[0]);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL latch cyc=%0d got=%b exp=%b", cyc, o, e);
         end
      end
      checks++;
      if (STATE_OUT !== 4'b0100) begin
         errors++;
         $display("FAIL latch_state got=%b exp=0100", STATE_OUT);
      end
      checks++;
      if (ticks_seen != 2) begin
         errors++;
         $display("FAIL frame_tick_rate got=%0d exp=2", ticks_seen);
      end
   endtask

   task automatic test_scan_disable();
      logic [11:0] e, o;
      logic [6:0]  e0, o0;
      for (int i = 0; i < 2 * FRAME && (m_t % FRAME) != SD + 3; i++) begin
         tick(e, o, e0, o0);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL dis_pre cyc=%0d got=%b exp=%b", cyc, o, e);
         end
      end
      SCAN_EN = 1'b0;
      STATE_IN = 4'b1001;
      tick(e, o, e0, o0);
      checks++;
      if (o !== e || o !== {4'b1111, 3'd0, 4'b0100, 1'b0}) begin
         errors++;
         $display("FAIL disable cyc=%0d got=%b exp=%b", cyc, o, e);
      end
      SCAN_EN = 1'b1;
      repeat (FRAME + 4) begin
         tick(e, o, e0, o0);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL restart cyc=%0d got=%b exp=%b", cyc, o, e);
         end
      end
   endtask

   task automatic test_midreset();
      logic [11:0] e, o;
      logic [6:0]  e0, o0;
      for (int i = 0; i < 2 * FRAME && (m_t % FRAME) != 2 * SD + 4; i++) begin
         tick(e, o, e0, o0);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL rst_pre cyc=%0d got=%b exp=%b", cyc, o, e);
         end
      end
      nRST = 1'b0;
      tick(e, o, e0, o0);
      checks++;
      if (o !== e || o !== 12'b1111_000_0000_0) begin
         errors++;
         $display("FAIL midreset cyc=%0d got=%b exp=%b", cyc, o, e);
      end
      nRST = 1'b1;
      repeat (FRAME + 4) begin
         tick(e, o, e0, o0);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL post_rst cyc=%0d got=%b exp=%b", cyc, o, e);
         end
      end
   endtask

   task automatic test_no_blank();
      logic [11:0] e, o;
      logic [6:0]  e0, o0;
      nRST = 1'b0;
      tick(e, o, e0, o0);
      nRST = 1'b1; SCAN_EN = 1'b1; STATE_IN = 4'b0010;
      repeat (FRAME + 8) begin
         tick(e, o, e0, o0);
         checks++;
         if (o0 !== e0 || o0[6:3] === 4'b1111) begin
            errors++;
            $display("FAIL no_blank cyc=%0d got=%b exp=%b", cyc, o0, e0);
         end
      end
   endtask

   task automatic test_blink();
      logic [11:0] e, o;
      logic [6:0]  e0, o0;
      int dark_cnt;
      int exp_dark;
`ifdef SEG7_BLINK_EN
      exp_dark = 2 * ND * (SD - BC);
`else
      exp_dark = 0;
`endif
      nRST = 1'b0;
      tick(e, o, e0, o0);
      nRST = 1'b1; SCAN_EN = 1'b1; STATE_IN = 4'b0111;
      dark_cnt = 0;
      repeat (6 * FRAME) begin
         tick(e, o, e0, o0);
         if ((m_t % SD) >= BC && o[11:8] === 4'b1111) dark_cnt++;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL blink_wrong cyc=%0d got=%b exp=%b", cyc, o, e);
         end
      end
      checks++;
      if (dark_cnt != exp_dark) begin
         errors++;
         $display("FAIL blink_dark_count got=%0d exp=%0d", dark_cnt, exp_dark);
      end
      STATE_IN = 4'b0100;
      dark_cnt = 0;
      repeat (6 * FRAME) begin
         tick(e, o, e0, o0);
         if ((m_t % SD) >= BC && o[11:8] === 4'b1111) dark_cnt++;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL blink_play cyc=%0d got=%b exp=%b", cyc, o, e);
         end
      end
      checks++;
      if (dark_cnt != 0) begin
         errors++;
         $display("FAIL blink_never_dark got=%0d exp=0", dark_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_frame_latch();
      test_scan_disable();
      test_midreset();
      test_no_blank();
      test_blink();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
